// File: rtl/modulus_n_down_counter_if.sv
// ---------------------------------------------------------------------------
// modulus_n_down_counter_if
//   Control/status bundle for the modulus-N down counter.
//   master : the block that drives enable/load and observes the count.
//   slave  : the counter itself.
//   Optional macro MODN_DOWN_WRAP_CNT_EN adds the 8-bit wrap_cnt status field.
// ---------------------------------------------------------------------------
interface modulus_n_down_counter_if #(
  parameter int WIDTH = 3
);

  logic             en;        // count enable
  logic             load;      // synchronous parallel load strobe
  logic [WIDTH-1:0] load_val;  // value to load (clamped by the counter)
  logic [WIDTH-1:0] q;         // registered count
  logic             zero;      // q == 0
  logic             borrow;    // one-cycle pulse after a 0 -> MODULUS-1 wrap
`ifdef MODN_DOWN_WRAP_CNT_EN
  logic [7:0]       wrap_cnt;  // saturating borrow-event count
`endif

`ifdef MODN_DOWN_WRAP_CNT_EN
  modport master (
    output en, load, load_val,
    input  q, zero, borrow, wrap_cnt
  );

  modport slave (
    input  en, load, load_val,
    output q, zero, borrow, wrap_cnt
  );
`else
  modport master (
    output en, load, load_val,
    input  q, zero, borrow
  );

  modport slave (
    input  en, load, load_val,
    output q, zero, borrow
  );
`endif

endinterface : modulus_n_down_counter_if

// File: rtl/modulus_n_down_counter.sv
// ---------------------------------------------------------------------------
// modulus_n_down_counter
//   Programmable modulus-N down counter: MODULUS-1 .. 0, then wraps back to
//   MODULUS-1. Per edge the priority is load > en > hold. A load clamps
//   out-of-range values to MODULUS-1, so the count can never leave
//   0 .. MODULUS-1. The borrow pulse is registered and is high for exactly
//   the cycle following a wrap edge, i.e. together with q == MODULUS-1;
//   it is used to cascade digits or as a periodic tick.
//
//   Optional macro MODN_DOWN_WRAP_CNT_EN adds wrap_cnt: a saturating count of
//   borrow events since reset or the last load.
// ---------------------------------------------------------------------------
module modulus_n_down_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  modulus_n_down_counter_if.slave  bus
);

  // -------------------------------------------------------------------------
  // Configuration check: an illegal modulus cannot be represented or would
  // make the wrap value meaningless, so refuse to elaborate.
  // -------------------------------------------------------------------------
  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_cfg_error
    $fatal(1, "modulus_n_down_counter: MODULUS must be in 2 .. 2**WIDTH");
  end

  // Terminal (wrap-to) value of the count.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  // -------------------------------------------------------------------------
  // State and next-state signals
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] r_q;
  logic             r_borrow;
  logic [WIDTH-1:0] w_q_next;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_load_val_clamped;
  logic             w_at_zero;

  // Clamp the load value into the legal range so a load cannot create an
  // unreachable state.
  assign w_load_val_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;

  // The wrap decision is taken on the current count.
  assign w_at_zero = (r_q == '0);

  // Next-state selection: load beats en, en beats hold; borrow only on a wrap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    w_q_next      = r_q;
    w_borrow_next = 1'b0;
    if (bus.load) begin
      w_q_next      = w_load_val_clamped;
      w_borrow_next = 1'b0;
    end else if (bus.en) begin
      if (w_at_zero) begin
        w_q_next      = MAX_VAL;
        w_borrow_next = 1'b1;
      end else begin
        w_q_next      = r_q - WIDTH'(1);
        w_borrow_next = 1'b0;
      end
    end
  end

  // Count and borrow registers; reset clears both without needing a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= '0;
      r_borrow <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      r_q      <= w_q_next;
      r_borrow <= w_borrow_next;
    end
  end

  // -------------------------------------------------------------------------
  // Optional wrap-event counter
  // -------------------------------------------------------------------------
`ifdef MODN_DOWN_WRAP_CNT_EN
  logic [7:0] r_wrap_cnt;
  logic [7:0] w_wrap_cnt_next;

  // Clear on load, bump on the same edge that raises borrow, stop at 255.
  always_comb begin
    w_wrap_cnt_next = r_wrap_cnt;
    if (bus.load) begin
      w_wrap_cnt_next = 8'd0;
    end else if (w_borrow_next && (r_wrap_cnt != 8'hFF)) begin
      w_wrap_cnt_next = r_wrap_cnt + 8'd1;
    end
  end

  // Wrap counter register, cleared asynchronously with the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap_cnt <= 8'd0;
    end else begin
      r_wrap_cnt <= w_wrap_cnt_next;
    end
  end

  assign bus.wrap_cnt = r_wrap_cnt;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.q      = r_q;
  assign bus.zero   = w_at_zero;
  assign bus.borrow = r_borrow;

endmodule : modulus_n_down_counter
